overlap_add_synth: RTL

- Inverse of the sliding-window capture in the FFT front end.
- Accepts a stream of real time-domain windows (WIN samples each, e.g. IFFT output) and overlap-adds consecutive windows with hop STEP.
- Emits a continuous sample stream over a valid/ready handshake.
- After FRAMES windows of one utterance, flushes the accumulator tail and marks the final sample with out_last.

---
 rtl/overlap_add_synth_if.sv | 21 ++
 rtl/overlap_add_synth.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/overlap_add_synth_if.sv
// Streaming handshake bundle for overlap_add_synth: window samples in, overlap-added samples out.
interface overlap_add_synth_if #(parameter int DW = 16) ();
  logic signed [DW-1:0] in_data;
  logic                 in_last;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] out_data;
  logic                 out_last;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output in_data, in_last, in_valid, out_ready,
    input  in_ready, out_data, out_last, out_valid
  );

  modport slave (
    input  in_data, in_last, in_valid, out_ready,
    output in_ready, out_data, out_last, out_valid
  );
endinterface

// File: rtl/overlap_add_synth.sv
// Overlap-add synthesis: accumulates WIN-sample windows at hop STEP and streams the result.
// Optional macro OLA_SATURATE_EN: saturating output conversion plus sticky sat_hit flag.
module overlap_add_synth #(
  parameter int WIN    = 512,
  parameter int STEP   = 160,
  parameter int FRAMES = 100,
  parameter int DW     = 16
) (
  input  logic clk,
  input  logic arstn,
  input  logic start,
  overlap_add_synth_if.slave bus,
  output logic active,
`ifdef OLA_SATURATE_EN
  output logic sat_hit,
`endif
  output logic frame_err
);
  localparam int NOV      = (WIN + STEP - 1) / STEP;
  localparam int ACC_W    = DW + $clog2(NOV);
  localparam int AW       = (WIN > 1) ? $clog2(WIN) : 1;
  localparam int FW       = $clog2(FRAMES + 1);
  localparam bit NO_FLUSH = (WIN == STEP);
  localparam int FLUSH_N  = (WIN > STEP) ? (WIN - STEP) : 1;

  typedef enum logic [1:0] {IDLE, ACCUM, EMIT, FLUSH} state_t;

  state_t                   state, state_nxt;
  logic signed [ACC_W-1:0]  acc [WIN];
  logic [AW-1:0]            base, k, j;
  logic [FW-1:0]            frames_done;
  logic [AW-1:0]            addr_in, addr_out;
  logic signed [ACC_W-1:0]  acc_out;
  logic signed [DW-1:0]     conv_out;
  logic                     clip;
  logic                     k_last, j_last_emit, j_last_flush, last_frame;

  function automatic logic [AW-1:0] wrap(input logic [AW-1:0] b, input logic [AW-1:0] o);
    logic [AW:0] s;
    s = {1'b0, b} + {1'b0, o};
    if (s >= (AW+1)'(WIN)) s = s - (AW+1)'(WIN);
    return s[AW-1:0];
  endfunction

  assign addr_in      = wrap(base, k);
  assign addr_out     = wrap(base, j);
  assign acc_out      = acc[addr_out];
  assign k_last       = (k == AW'(WIN - 1));
  assign j_last_emit  = (j == AW'(STEP - 1));
  assign j_last_flush = (j == AW'(FLUSH_N - 1));
  assign last_frame   = (frames_done == FW'(FRAMES - 1));

`ifdef OLA_SATURATE_EN
  localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((2 ** (DW - 1)) - 1);
  localparam logic signed [ACC_W-1:0] MINV = -ACC_W'(2 ** (DW - 1));
  always_comb begin
    clip     = 1'b0;
    conv_out = acc_out[DW-1:0];
    if (acc_out > MAXV) begin
      clip     = 1'b1;
      conv_out = MAXV[DW-1:0];
    end else if (acc_out < MINV) begin
      clip     = 1'b1;
      conv_out = MINV[DW-1:0];
    end
  end
`else
  assign clip     = 1'b0;
  assign conv_out = acc_out[DW-1:0];
`endif

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_last  = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = ACCUM;
      ACCUM: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid && k_last) state_nxt = EMIT;
      end
      EMIT: begin
        bus.out_valid = 1'b1;
        bus.out_last  = NO_FLUSH && j_last_emit && last_frame;
        if (bus.out_ready && j_last_emit) begin
          if (!last_frame)   state_nxt = ACCUM;
          else if (NO_FLUSH) state_nxt = IDLE;
          else               state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        bus.out_valid = 1'b1;
        bus.out_last  = j_last_flush;
        if (bus.out_ready && j_last_flush) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.out_data = bus.out_valid ? conv_out : '0;
  assign active       = (state != IDLE);

  // Emitted entries are zeroed on handshake so the slot is clean when the window wraps onto it.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      for (int i = 0; i < WIN; i++) acc[i] <= '0;
      base        <= '0;
      k           <= '0;
      j           <= '0;
      frames_done <= '0;
      frame_err   <= 1'b0;
`ifdef OLA_SATURATE_EN
      sat_hit     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          for (int i = 0; i < WIN; i++) acc[i] <= '0;
          base        <= '0;
          k           <= '0;
          j           <= '0;
          frames_done <= '0;
          frame_err   <= 1'b0;
`ifdef OLA_SATURATE_EN
          sat_hit     <= 1'b0;
`endif
        end
        ACCUM: if (bus.in_valid) begin
          acc[addr_in] <= acc[addr_in] + ACC_W'(bus.in_data);
          if (bus.in_last != k_last) frame_err <= 1'b1;
          k <= k_last ? '0 : k + 1'b1;
        end
        EMIT: if (bus.out_ready) begin
          acc[addr_out] <= '0;
`ifdef OLA_SATURATE_EN
          if (clip) sat_hit <= 1'b1;
`endif
          if (j_last_emit) begin
            j           <= '0;
            base        <= wrap(base, AW'(STEP % WIN));
            frames_done <= frames_done + FW'(1);
          end else begin
            j <= j + 1'b1;
          end
        end
        FLUSH: if (bus.out_ready) begin
          acc[addr_out] <= '0;
`ifdef OLA_SATURATE_EN
          if (clip) sat_hit <= 1'b1;
`endif
          j <= j_last_flush ? '0 : j + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
